// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer
//   Display-side end of the pixel_index -> pixel_data interface for the
//   SSD1331 PmodOLEDrgb (96x64, RGB565). Sequences panel power-up, sends
//   the fixed init command list, then streams pixels over 4-wire SPI forever.
//
// Ports
//   clock         in   1   system clock, all logic on posedge
//   reset_n       in   1   synchronous active-low reset
//   pixel_data    in   16  RGB565 colour for the current pixel_index
//   pixel_index   out  13  pixel address 0..6143 (y*96 + x)
//   sample_pixel  out  1   pixel_data is latched at the end of this cycle
//   frame_begin   out  1   sample_pixel for pixel 0
//   ready         out  1   high while streaming
//   cs_n, sclk, sdin, d_cn, resn, vccen, pmoden   SSD1331 pins
//
// State table
//   PWR_WAIT  | pmoden/resn high, let the panel supply settle
//   RES_LOW   | panel reset asserted
//   RES_HIGH  | panel reset released, wait before first command
//   INIT      | shift out the init command bytes (d_cn=0)
//   VCC_WAIT  | vccen high, let the panel high voltage settle
//   DISP_ON   | shift out display-on command
//   STREAM    | back-to-back 16-bit pixel words (d_cn=1), never exits

module oled_pixel_streamer #(
  parameter int CLK_DIV     = 8,
  parameter int POWER_DELAY = 2_000_000,
  parameter int RESET_LOW   = 1_000,
  parameter int VCC_DELAY   = 10_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        sample_pixel,
  output logic        frame_begin,
  output logic        ready,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam int MAX_A     = (POWER_DELAY > RESET_LOW) ? POWER_DELAY : RESET_LOW;
  localparam int MAX_DELAY = (MAX_A > VCC_DELAY) ? MAX_A : VCC_DELAY;
  localparam int TW        = $clog2(MAX_DELAY + 1);
  localparam int DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [12:0] LAST_PIXEL = 13'd6143;
  localparam logic [3:0]  INIT_LAST  = 4'd12;
  localparam logic [3:0]  GAP_SLOT   = 4'd8;
  localparam logic [3:0]  WORD_LAST  = 4'd15;

  typedef enum logic [2:0] {
    PWR_WAIT,
    RES_LOW,
    RES_HIGH,
    INIT,
    VCC_WAIT,
    DISP_ON,
    STREAM
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic          half_q, half_d;      // 0: sclk low half, 1: sclk high half
  logic [3:0]    bit_q, bit_d;        // slot within byte/word; slot 8 is the inter-command gap
  logic [3:0]    byte_q, byte_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          inc_pending_q;

  logic div_last, slot_end, engine_d, data_slot_d;
  logic cs_n_d, sclk_d, sdin_d, d_cn_d, resn_d, vccen_d;

  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    logic [7:0] cmd;
    case (idx)
      4'd0:    cmd = 8'hAE;
      4'd1:    cmd = 8'hA0;
      4'd2:    cmd = 8'h72;
      4'd3:    cmd = 8'hA1;
      4'd4:    cmd = 8'h00;
      4'd5:    cmd = 8'hA2;
      4'd6:    cmd = 8'h00;
      4'd7:    cmd = 8'hA4;
      4'd8:    cmd = 8'hA8;
      4'd9:    cmd = 8'h3F;
      4'd10:   cmd = 8'hAD;
      4'd11:   cmd = 8'h8E;
      4'd12:   cmd = 8'hB0;
      default: cmd = 8'h00;
    endcase
    return cmd;
  endfunction

  always_comb begin
    div_last = (div_q == DW'(CLK_DIV - 1));
    slot_end = half_q && div_last;

    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    half_d  = half_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;

    if (state_q inside {INIT, DISP_ON, STREAM}) begin
      div_d = div_last ? '0 : div_q + 1'b1;
      if (div_last) half_d = ~half_q;
    end

    case (state_q)
      // The reset cycle itself holds the pins at reset values, so PWR_WAIT
      // counts one extra to give POWER_DELAY cycles of visible power-on.
      PWR_WAIT: begin
        if (timer_q == TW'(POWER_DELAY)) begin
          state_d = RES_LOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RES_LOW: begin
        if (timer_q == TW'(RESET_LOW - 1)) begin
          state_d = RES_HIGH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RES_HIGH: begin
        if (timer_q == TW'(RESET_LOW - 1)) begin
          state_d = INIT;
          timer_d = '0;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          byte_d  = '0;
          shreg_d = {init_cmd(4'd0), 8'h00};
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      INIT: begin
        if (slot_end) begin
          if (bit_q == GAP_SLOT) begin
            if (byte_q == INIT_LAST) begin
              state_d = VCC_WAIT;
              timer_d = '0;
            end else begin
              byte_d  = byte_q + 4'd1;
              bit_d   = '0;
              shreg_d = {init_cmd(byte_q + 4'd1), 8'h00};
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      VCC_WAIT: begin
        if (timer_q == TW'(VCC_DELAY - 1)) begin
          state_d = DISP_ON;
          timer_d = '0;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          shreg_d = {8'hAF, 8'h00};
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DISP_ON: begin
        if (slot_end) begin
          if (bit_q == GAP_SLOT) begin
            state_d = STREAM;
            bit_d   = '0;
            shreg_d = pixel_data;
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      STREAM: begin
        if (slot_end) begin
          if (bit_q == WORD_LAST) begin
            bit_d   = '0;
            shreg_d = pixel_data;
          end else begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    // Pins are decoded from next-state values and registered, so they
    // change cleanly on the clock edge with no decode glitches.
    engine_d    = state_d inside {INIT, DISP_ON, STREAM};
    data_slot_d = engine_d && ((state_d == STREAM) || (bit_d != GAP_SLOT));
    cs_n_d      = !data_slot_d;
    sclk_d      = !(data_slot_d && !half_d);
    sdin_d      = data_slot_d && shreg_d[15];
    d_cn_d      = (state_d == STREAM);
    resn_d      = (state_d != RES_LOW);
    vccen_d     = state_d inside {VCC_WAIT, DISP_ON, STREAM};
  end

  // The last cycle of the DISP_ON gap and of every stream word is the one
  // whose closing edge loads the next pixel word.
  assign sample_pixel = slot_end &&
                        (((state_q == DISP_ON) && (bit_q == GAP_SLOT)) ||
                         ((state_q == STREAM)  && (bit_q == WORD_LAST)));
  assign frame_begin  = sample_pixel && (pixel_index == 13'd0);
  assign ready        = (state_q == STREAM);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= PWR_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timer_q       <= '0;
      div_q         <= '0;
      half_q        <= 1'b0;
      bit_q         <= '0;
      byte_q        <= '0;
      shreg_q       <= '0;
      inc_pending_q <= 1'b0;
      pixel_index   <= '0;
      cs_n          <= 1'b1;
      sclk          <= 1'b1;
      sdin          <= 1'b0;
      d_cn          <= 1'b0;
      resn          <= 1'b0;
      vccen         <= 1'b0;
      pmoden        <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      div_q         <= div_d;
      half_q        <= half_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      shreg_q       <= shreg_d;
      cs_n          <= cs_n_d;
      sclk          <= sclk_d;
      sdin          <= sdin_d;
      d_cn          <= d_cn_d;
      resn          <= resn_d;
      vccen         <= vccen_d;
      pmoden        <= 1'b1;
      // Index moves one cycle after the latch so the drawing logic sees the
      // old address on the latching edge itself.
      inc_pending_q <= sample_pixel;
      if (inc_pending_q) begin
        pixel_index <= (pixel_index == LAST_PIXEL) ? 13'd0 : pixel_index + 13'd1;
      end
    end
  end

endmodule

// File: tb/tb_oled_pixel_streamer.sv
module tb_oled_pixel_streamer;

  localparam int CLK_DIV     = 2;
  localparam int POWER_DELAY = 20;
  localparam int RESET_LOW   = 4;
  localparam int VCC_DELAY   = 30;
  localparam int WORD_CYC    = 32 * CLK_DIV;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pixel_data;
  logic [15:0] pd = 16'h0000;
  logic        use_idx = 1'b1;
  logic [12:0] pixel_index;
  logic        sample_pixel, frame_begin, ready;
  logic        cs_n, sclk, sdin, d_cn, resn, vccen, pmoden;

  oled_pixel_streamer #(
    .CLK_DIV    (CLK_DIV),
    .POWER_DELAY(POWER_DELAY),
    .RESET_LOW  (RESET_LOW),
    .VCC_DELAY  (VCC_DELAY)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pixel_data  (pixel_data),
    .pixel_index (pixel_index),
    .sample_pixel(sample_pixel),
    .frame_begin (frame_begin),
    .ready       (ready),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .sdin        (sdin),
    .d_cn        (d_cn),
    .resn        (resn),
    .vccen       (vccen),
    .pmoden      (pmoden)
  );

  // A drawing module returns the colour for pixel_index combinationally.
  assign pixel_data = use_idx ? {3'b000, pixel_index} : pd;

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       dc;
  } cmd_vec_t;

  typedef struct {
    logic [15:0] pix;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } pix_vec_t;

  cmd_vec_t cmd_tbl [14];
  pix_vec_t pix_tbl [8];

  logic [8:0]  cmd_q [$];
  logic [15:0] dec_q [$];
  logic [15:0] exp_q [$];

  // SPI slave + scoreboard, sampled on the falling system clock edge.
  int          cyc = 0;
  int          last_cyc = 0;
  bit          have_last = 1'b0;
  int          nbits = 0;
  logic [15:0] sh = '0;
  logic        sclk_prev = 1'b1;
  logic [12:0] tb_idx = '0;
  int          fb_count = 0;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      tb_idx    = '0;
      have_last = 1'b0;
      nbits     = 0;
      fb_count  = 0;
      sclk_prev = 1'b1;
    end else begin
      if (frame_begin) fb_count++;
      if (sample_pixel) begin
        check("sample_index", pixel_index, tb_idx);
        check("frame_begin", frame_begin, tb_idx == 13'd0);
        if (ready) check("stream_cs_dc", {cs_n, d_cn}, 2'b01);
        if (have_last) check("sample_period", cyc - last_cyc, WORD_CYC);
        last_cyc  = cyc;
        have_last = 1'b1;
        exp_q.push_back(use_idx ? {3'b000, tb_idx} : pd);
        tb_idx = (tb_idx == 13'd6143) ? 13'd0 : tb_idx + 13'd1;
      end
      if (cs_n) begin
        nbits = 0;
      end else if (sclk && !sclk_prev) begin
        sh = {sh[14:0], sdin};
        nbits++;
        if (!ready && nbits == 8) begin
          cmd_q.push_back({d_cn, sh[7:0]});
          nbits = 0;
        end else if (ready && nbits == 16) begin
          dec_q.push_back(sh);
          if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
          else check("stream_word", sh, exp_q.pop_front());
          nbits = 0;
        end
      end
      sclk_prev = sclk;
    end
  end

  task automatic wait_sample();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sample_pixel && n < 4 * WORD_CYC);
    check("sample_seen", sample_pixel, 1);
  endtask

  task automatic do_powerup();
    int n;
    reset_n = 1'b0;
    cmd_q.delete();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_pins", {cs_n, sclk, sdin, d_cn, resn, vccen, pmoden, ready, sample_pixel, frame_begin},
          10'b1100000000);
    check("reset_index", pixel_index, 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("pmoden_on", pmoden, 1);
    n = 0;
    while (resn === 1'b1 && n < 100) begin n++; @(negedge clock); end
    check("resn_high_cycles", n, POWER_DELAY);
    n = 0;
    while (resn === 1'b0 && n < 100) begin n++; @(negedge clock); end
    check("resn_low_cycles", n, RESET_LOW);
    check("resn_released", {resn, pmoden}, 2'b11);
    n = 0;
    while (vccen !== 1'b1 && n < 3000) begin @(negedge clock); n++; end
    check("vccen_rise", vccen, 1);
    n = 0;
    while (vccen === 1'b1 && cs_n === 1'b1 && n < 200) begin n++; @(negedge clock); end
    check("vcc_wait_cycles", n, VCC_DELAY);
    n = 0;
    while (ready !== 1'b1 && n < 500) begin @(negedge clock); n++; end
    check("ready_rise", ready, 1);
    check("cmd_count", cmd_q.size(), 14);
    for (int i = 0; i < 14; i++) begin
      if (i < cmd_q.size()) check("init_cmd", cmd_q[i], {cmd_tbl[i].dc, cmd_tbl[i].cmd});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    cmd_tbl[0]  = '{8'hAE, 1'b0};
    cmd_tbl[1]  = '{8'hA0, 1'b0};
    cmd_tbl[2]  = '{8'h72, 1'b0};
    cmd_tbl[3]  = '{8'hA1, 1'b0};
    cmd_tbl[4]  = '{8'h00, 1'b0};
    cmd_tbl[5]  = '{8'hA2, 1'b0};
    cmd_tbl[6]  = '{8'h00, 1'b0};
    cmd_tbl[7]  = '{8'hA4, 1'b0};
    cmd_tbl[8]  = '{8'hA8, 1'b0};
    cmd_tbl[9]  = '{8'h3F, 1'b0};
    cmd_tbl[10] = '{8'hAD, 1'b0};
    cmd_tbl[11] = '{8'h8E, 1'b0};
    cmd_tbl[12] = '{8'hB0, 1'b0};
    cmd_tbl[13] = '{8'hAF, 1'b0};
    pix_tbl[0]  = '{16'hF800, 8'hF8, 8'h00};
    pix_tbl[1]  = '{16'hF800, 8'hF8, 8'h00};
    pix_tbl[2]  = '{16'hF800, 8'hF8, 8'h00};
    pix_tbl[3]  = '{16'h07E0, 8'h07, 8'hE0};
    pix_tbl[4]  = '{16'h001F, 8'h00, 8'h1F};
    pix_tbl[5]  = '{16'hA55A, 8'hA5, 8'h5A};
    pix_tbl[6]  = '{16'h0000, 8'h00, 8'h00};
    pix_tbl[7]  = '{16'hFFFF, 8'hFF, 8'hFF};

    // Power-up, init list, then index-pattern stream from pixel 0.
    use_idx = 1'b1;
    do_powerup();
    repeat (40) wait_sample();
    check("frame_begin_count", fb_count, 1);

    // Table of colours; each word's source is disturbed right after latching.
    @(posedge clock);
    #2;
    use_idx = 1'b0;
    base = 0;
    for (int i = 0; i < 8; i++) begin
      pd = pix_tbl[i].pix;
      wait_sample();
      if (i == 0) base = dec_q.size();
      @(posedge clock);
      #2 pd = ~pix_tbl[i].pix;
      repeat (10) @(posedge clock);
      #2;
    end
    n = 0;
    while (dec_q.size() < base + 8 && n < 4 * WORD_CYC) begin @(negedge clock); n++; end
    check("table_words_seen", dec_q.size() >= base + 8, 1);
    for (int i = 0; i < 8; i++) begin
      if (base + i < dec_q.size())
        check("table_word", dec_q[base + i], {pix_tbl[i].hi, pix_tbl[i].lo});
    end

    // Abort mid-word: five bits into a stream word.
    use_idx = 1'b1;
    wait_sample();
    @(posedge clock);
    repeat (5 * 2 * CLK_DIV) @(posedge clock);
    #2 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_pins", {cs_n, sclk, ready}, 3'b110);
    check("abort_index", pixel_index, 0);

    // Whole sequence again, stream restarts at pixel 0.
    do_powerup();
    repeat (5) wait_sample();
    check("frame_begin_count_2", fb_count, 1);
    repeat (WORD_CYC + 6) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
